share_xor_accum: RTL and testbench



---
 rtl/share_pkg.sv | 30 +++
 rtl/share_xor2.sv | 12 +
 rtl/share_xor_accum.sv | 134 +++++++++++++
 tb/tb_share_xor_accum.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/share_pkg.sv
// Shared constants and helpers for the share-domain XOR accumulator.
package share_pkg;

    localparam int DEFAULT_N      = 8;
    localparam int DEFAULT_SHARES = 3;

    typedef enum logic [0:0] {
        ACC  = 1'b0,
        FULL = 1'b1
    } accum_state_t;

    // Bits needed to hold values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >>> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int share_width(input int n);
        return n;
    endfunction

    function automatic int share_offset(input int k, input int n);
        return k * share_width(n);
    endfunction

endpackage

// File: rtl/share_xor2.sv
// One share's N-bit two-input XOR, kept as its own instance so shares stay separable in the netlist.
module share_xor2 #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] y
);

    assign y = a ^ b;

endmodule

// File: rtl/share_xor_accum.sv
// Share-wise XOR accumulator: TERMS shared operands in, one registered shared sum out.
// Optional output re-randomisation is enabled with the macro SHARE_XOR_ACCUM_REFRESH_EN.
module share_xor_accum
    import share_pkg::*;
#(
    parameter int N      = DEFAULT_N,
    parameter int SHARES = DEFAULT_SHARES,
    parameter int TERMS  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SHARES*N-1:0]   in_shares,
`ifdef SHARE_XOR_ACCUM_REFRESH_EN
    input  logic [(SHARES-1)*N-1:0] rnd,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [SHARES*N-1:0]   out_shares
);

    localparam int CNT_W = clog2(TERMS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

    accum_state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SHARES*N-1:0] acc_q, acc_d;
    logic accept, first_beat, last_beat, acc_we;

    assign in_ready   = (state_q == ACC);
    assign out_valid  = (state_q == FULL);
    assign out_shares = acc_q;

    assign accept     = in_valid && in_ready && !flush;
    assign first_beat = (cnt_q == '0);
    assign last_beat  = (cnt_q == LAST_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (acc_we) begin
                acc_q <= acc_d;
            end
        end
    end

    // Flush wins over both handshakes; acc is left as-is because the next beat reloads it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_we  = 1'b0;
        if (flush) begin
            state_d = ACC;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ACC: begin
                    if (accept) begin
                        acc_we = 1'b1;
                        if (last_beat) begin
                            state_d = FULL;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        state_d = ACC;
                    end
                end
                default: begin
                    state_d = ACC;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef SHARE_XOR_ACCUM_REFRESH_EN
    logic [N-1:0] rnd_fold;
    logic         refresh;

    assign refresh = accept && last_beat;

    // Folding the random slices together keeps the unmasked sum unchanged.
    always_comb begin
        rnd_fold = '0;
        for (int j = 0; j < SHARES - 1; j++) begin
            rnd_fold = rnd_fold ^ rnd[j*N +: N];
        end
    end
`endif

    for (genvar k = 0; k < SHARES; k++) begin : g_share
        localparam int OFF = share_offset(k, N);
        logic [N-1:0] sum_k, base_k;

        share_xor2 #(.N(N)) u_xor (
            .a (acc_q[OFF +: N]),
            .b (in_shares[OFF +: N]),
            .y (sum_k)
        );

        assign base_k = first_beat ? in_shares[OFF +: N] : sum_k;

`ifdef SHARE_XOR_ACCUM_REFRESH_EN
        logic [N-1:0] mask_k;

        if (k < SHARES - 1) begin : g_mask_slice
            assign mask_k = refresh ? rnd[OFF +: N] : '0;
        end else begin : g_mask_fold
            assign mask_k = refresh ? rnd_fold : '0;
        end

        share_xor2 #(.N(N)) u_refresh (
            .a (base_k),
            .b (mask_k),
            .y (acc_d[OFF +: N])
        );
`else
        assign acc_d[OFF +: N] = base_k;
`endif
    end

endmodule

// File: tb/tb_share_xor_accum.sv
// Self-checking bench for share_xor_accum (TERMS=4 main instance plus a TERMS=1 instance).
module tb_share_xor_accum;

    localparam int N      = 8;
    localparam int SHARES = 3;
    localparam int TERMS  = 4;
    localparam int W      = SHARES * N;
    localparam int RW     = (SHARES - 1) * N;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  in_shares, out_shares;
    logic          in1_valid, in1_ready, out1_valid, out1_ready;
    logic [W-1:0]  in1_shares, out1_shares;
    logic [RW-1:0] rnd_val;

`ifdef SHARE_XOR_ACCUM_REFRESH_EN
    logic [RW-1:0] rnd1;
    assign rnd1 = '0;
`endif

    share_xor_accum #(.N(N), .SHARES(SHARES), .TERMS(TERMS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_shares  (in_shares),
`ifdef SHARE_XOR_ACCUM_REFRESH_EN
        .rnd        (rnd_val),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares)
    );

    share_xor_accum #(.N(N), .SHARES(SHARES), .TERMS(1)) dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (1'b0),
        .in_valid   (in1_valid),
        .in_ready   (in1_ready),
        .in_shares  (in1_shares),
`ifdef SHARE_XOR_ACCUM_REFRESH_EN
        .rnd        (rnd1),
`endif
        .out_valid  (out1_valid),
        .out_ready  (out1_ready),
        .out_shares (out1_shares)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;
    int fail_cnt  = 0;
    logic [W-1:0] ops[$];

    task automatic checkOutput(input string tag, input logic [W-1:0] observed, input logic [W-1:0] expected);
        check_cnt++;
        assert (observed === expected) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Random 3-share encoding of an unmasked byte.
    function automatic logic [W-1:0] mask_value(input logic [N-1:0] u);
        logic [N-1:0] s0, s1;
        s0 = N'($urandom);
        s1 = N'($urandom);
        return {u ^ s0 ^ s1, s1, s0};
    endfunction

    function automatic logic [W-1:0] unmask(input logic [W-1:0] x);
        return W'(x[7:0] ^ x[15:8] ^ x[23:16]);
    endfunction

    // Reference: share-wise XOR of every operand, then the optional refresh mask.
    function automatic logic [W-1:0] expected_result(input logic [W-1:0] q[$], input logic [RW-1:0] r);
        logic [W-1:0] s;
        s = '0;
        foreach (q[i]) s = s ^ q[i];
`ifdef SHARE_XOR_ACCUM_REFRESH_EN
        s = s ^ {r[7:0] ^ r[15:8], r};
`else
        if (r == '1) s = s;
`endif
        return s;
    endfunction

    // Presents one operand and returns #1 after the edge that accepted it.
    task automatic applyStimulus(input logic [W-1:0] op);
        int t;
        in_shares = op;
        in_valid  = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        if (t == 50) checkOutput("accept_timeout", W'(in_ready), W'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic sendValue(input logic [N-1:0] u);
        logic [W-1:0] op;
        op = mask_value(u);
        ops.push_back(op);
        applyStimulus(op);
    endtask

    task automatic drainOutput(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, "_drained_valid"}, W'(out_valid), W'(0));
        checkOutput({tag, "_drained_ready"}, W'(in_ready), W'(1));
    endtask

    task automatic checkResult(input string tag, input logic [N-1:0] unmasked);
        logic [W-1:0] exp_v;
        exp_v = expected_result(ops, rnd_val);
        checkOutput({tag, "_valid"}, W'(out_valid), W'(1));
        checkOutput({tag, "_in_ready"}, W'(in_ready), W'(0));
        checkOutput({tag, "_shares"}, out_shares, exp_v);
        checkOutput({tag, "_unmasked"}, unmask(out_shares), W'(unmasked));
    endtask

    initial begin
        logic [W-1:0] held, pend, op1, nxt;
        logic [N-1:0] u, acc_u;
        int dly;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_shares = '0; out_ready = 1'b0;
        in1_valid = 1'b0; in1_shares = '0; out1_ready = 1'b1; rnd_val = 16'hC35A;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", W'(in_ready), W'(1));
        checkOutput("rst_out_valid", W'(out_valid), W'(0));
        checkOutput("rst_out_shares", out_shares, '0);
        checkOutput("rst_t1_out_valid", W'(out1_valid), W'(0));
        @(posedge clk); #1;

        $display("[TB] basic 1,2,4,8 accumulation");
        ops.delete();
        for (int i = 0; i < 4; i++) begin
            sendValue(N'(1 << i));
            if (i < 3) checkOutput("basic_no_early_valid", W'(out_valid), W'(0));
        end
        checkResult("basic", 8'h0F);

        $display("[TB] backpressure with a waiting operand");
        held = out_shares;
        pend = mask_value(8'h11);
        in_shares = pend;
        in_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bp_stable", out_shares, held);
            checkOutput("bp_in_ready", W'(in_ready), W'(0));
        end
        drainOutput("bp");
        @(posedge clk); #1;
        in_valid = 1'b0;
        ops.delete();
        ops.push_back(pend);
        sendValue(8'h22);
        sendValue(8'h44);
        sendValue(8'h88);
        checkResult("bp_pending", 8'hFF);
        drainOutput("bp2");

        $display("[TB] flush after two beats");
        ops.delete();
        sendValue(N'($urandom));
        sendValue(N'($urandom));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        ops.delete();
        sendValue(8'hAA);
        sendValue(8'h55);
        sendValue(8'h00);
        sendValue(8'hFF);
        checkResult("flush", 8'h00);
        drainOutput("flush");

        $display("[TB] reset during FULL and mid-accumulation");
        ops.delete();
        for (int i = 0; i < 4; i++) sendValue(N'($urandom));
        checkOutput("rstfull_pre_valid", W'(out_valid), W'(1));
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstfull_out_valid", W'(out_valid), W'(0));
        checkOutput("rstfull_out_shares", out_shares, '0);
        @(posedge clk); #1 rst_n = 1'b1;
        #1;
        checkOutput("rstfull_in_ready", W'(in_ready), W'(1));
        ops.delete();
        sendValue(N'($urandom));
        sendValue(N'($urandom));
        #2 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        ops.delete();
        acc_u = '0;
        for (int i = 0; i < 4; i++) begin
            u = N'($urandom);
            acc_u = acc_u ^ u;
            sendValue(u);
        end
        checkResult("rstmid", acc_u);
        drainOutput("rstmid");

        $display("[TB] TERMS=1 pass-through");
        op1 = mask_value(N'($urandom));
        in1_shares = op1;
        in1_valid  = 1'b1;
        for (int i = 0; i < 6; i++) begin
            checkOutput("t1_ready_acc", W'(in1_ready), W'(1));
            @(posedge clk); #1;
            checkOutput("t1_valid", W'(out1_valid), W'(1));
            checkOutput("t1_shares", out1_shares, op1);
            checkOutput("t1_ready_full", W'(in1_ready), W'(0));
            nxt = mask_value(N'($urandom));
            in1_shares = nxt;
            @(posedge clk); #1;
            checkOutput("t1_valid_gap", W'(out1_valid), W'(0));
            op1 = nxt;
        end
        in1_valid = 1'b0;

        $display("[TB] randomized rounds");
        for (int r = 0; r < 6; r++) begin
            rnd_val = RW'($urandom);
            ops.delete();
            acc_u = '0;
            for (int i = 0; i < 4; i++) begin
                u = N'($urandom);
                acc_u = acc_u ^ u;
                sendValue(u);
            end
            checkResult("rand", acc_u);
            held = out_shares;
            dly = int'($urandom_range(0, 3));
            for (int d = 0; d < dly; d++) begin
                @(posedge clk); #1;
                checkOutput("rand_hold", out_shares, held);
            end
            drainOutput("rand");
        end

        $display("[TB] %0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
